mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the fetch port and the
//  load/store port of the RV32I core. It removes the need for a second RAM port.
//  Sits between ctrl/datapath and the unified instruction/data RAM.
//  Keeps one read transaction in flight at a time.
//  Data accesses have priority over fetch, with a starvation guard for fetch.
// PARAMETERS
//  MEM_LAT     1  read latency of memory in cycles (legal 1..4)
//  STARVE_MAX  4  max consecutive data grants while if_req pending (legal 1..15)
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   synchronous reset, active-high
//  if_req     in   1   fetch read request; hold with if_addr stable until if_gnt
//  if_addr    in   32  fetch byte address (word aligned)
//  if_gnt     out  1   fetch request accepted this cycle
//  if_rvalid  out  1   fetch read data valid (1-cycle pulse)
//  if_rdata   out  32  fetch read data
//  d_req      in   1   load/store request; hold all d_* stable until d_gnt
//  d_wen      in   1   1 = store, 0 = load
//  d_mode     in   3   funct3 size/sign mode, passed to memory
//  d_addr     in   32  load/store byte address
//  d_wdata    in   32  store data
//  d_gnt      out  1   data request accepted this cycle
//  d_rvalid   out  1   load data valid (1-cycle pulse; never for stores)
//  d_rdata    out  32  load data
//  mem_en     out  1   memory access strobe
//  mem_wen    out  1   memory write enable
//  mem_mode   out  3   memory size/sign mode
//  mem_addr   out  32  memory address
//  mem_wdata  out  32  memory write data
//  mem_rdata  in   32  memory read data, valid MEM_LAT cycles after mem_en read
// BEHAVIOUR
//  - State: IDLE, BUSY_IF, BUSY_D.
//    Latency counter lat_cnt[2:0]; owner flag; starvation counter st_cnt[3:0].
//  - Arbitration slot: state IDLE, or BUSY_* with lat_cnt == MEM_LAT-1
//    (the cycle the response returns). This gives back-to-back reads at full rate.
//  - In a slot, the winner is chosen combinationally:
//    d_req && !(if_req && st_cnt == STARVE_MAX) -> data;
//    else if_req -> fetch; else none.
//  - Grant cycle T: gnt=1 to the winner only.
//    mem_en=1; mem_addr, mem_wen, mem_mode, mem_wdata are driven from the winner.
//    Fetch drives mem_wen=0, mem_mode=3'b010, mem_wdata=0.
//  - No grant: mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_mode=3'b010.
//  - Read grant -> BUSY_IF/BUSY_D with lat_cnt=0; lat_cnt increments each cycle.
//  - Response: the owner's rvalid=1 in cycle T+MEM_LAT, with rdata=mem_rdata.
//    rdata is 0 when rvalid=0.
//    Return to IDLE after that cycle unless a new read is granted in the same slot.
//  - Store grant: single-cycle and posted. No rvalid. State stays IDLE,
//    or returns to IDLE if granted in a response slot.
//  - st_cnt: +1 (saturating at STARVE_MAX) on each data grant while if_req=1.
//    Clears on any fetch grant, or on any cycle with if_req=0.
//  - No grant in cycles outside a slot (mid-latency); requests wait.
//  - Simultaneous if_req and d_req with st_cnt<STARVE_MAX: data wins, fetch waits.
//  - MEM_LAT=1: BUSY lasts exactly one cycle, which is itself a slot.
//  - Reset: state IDLE, lat_cnt=0, st_cnt=0. All outputs 0 except
//    mem_mode=3'b010. A reset mid-read discards the response (no rvalid
//    afterwards); the requester re-issues.
//  - Request withdrawn before gnt: protocol violation; assertion in sim only.
// TESTING
//  1 MEM_LAT=1, if_req only, addr 0x0,0x4,0x8 -> gnt every cycle,
//    if_rvalid cycles 1,2,3, data matches RAM.
//  2 MEM_LAT=2, if_req+d_req(load 0x100) same cycle -> d_gnt T, d_rvalid T+2;
//    if_gnt T+2, if_rvalid T+4.
//  3 d_req store 0x200=0xDEADBEEF, mode 010, then load 0x200
//    -> no d_rvalid for store; load returns 0xDEADBEEF.
//  4 STARVE_MAX=4, d_req held with 6 loads, if_req held
//    -> 4 data grants, then if_gnt, then remaining data grants.
//  5 MEM_LAT=3, rst asserted 1 cycle after a fetch gnt
//    -> no if_rvalid afterwards; outputs at reset values next cycle.
//  6 MEM_LAT=2, store granted in response slot of a fetch
//    -> if_rvalid and mem_wen=1 same cycle; next cycle IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Fetch / load-store / memory bundle for the shared RAM port.
// master = arbiter side; slave = requesters and the memory.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_wen;
  logic [2:0]  d_mode;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_wen;
  logic [2:0]  mem_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  if_req, if_addr,
    input  d_req, d_wen, d_mode, d_addr, d_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_wen, mem_mode,
    output mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr,
    output d_req, d_wen, d_mode, d_addr, d_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_wen, mem_mode,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: fetch vs load/store, one read in flight,
// data priority with a starvation guard for fetch.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_D
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);
  localparam logic [3:0] ST_MAX   = 4'(STARVE_MAX);
  localparam logic [2:0] WORD     = 3'b010;

  state_t     state, state_nx;
  logic [2:0] lat_cnt, lat_nx;
  logic [3:0] st_cnt, st_nx;

  logic resp;
  logic slot;
  logic starved;
  logic win_d;
  logic win_if;

  // the response cycle doubles as the next arbitration slot
  always_comb begin
    resp    = !rst && (state != IDLE) && (lat_cnt == LAT_LAST);
    slot    = !rst && ((state == IDLE) || resp);
    starved = bus.if_req && (st_cnt == ST_MAX);
    win_d   = slot && bus.d_req && !starved;
    win_if  = slot && !win_d && bus.if_req;
  end

  always_comb begin
    bus.d_gnt     = 1'b0;
    bus.if_gnt    = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_mode  = WORD;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      win_d: begin
        bus.d_gnt     = 1'b1;
        bus.mem_en    = 1'b1;
        bus.mem_wen   = bus.d_wen;
        bus.mem_mode  = bus.d_mode;
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
      end
      win_if: begin
        bus.if_gnt   = 1'b1;
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.if_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.if_rvalid = resp && (state == BUSY_IF);
    bus.d_rvalid  = resp && (state == BUSY_D);
    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;
  end

  always_comb begin
    state_nx = state;
    lat_nx   = lat_cnt + 3'd1;
    st_nx    = st_cnt;
    if ((state == IDLE) || resp) begin
      state_nx = IDLE;
      lat_nx   = '0;
      if (win_if)
        state_nx = BUSY_IF;
      else if (win_d && !bus.d_wen)
        state_nx = BUSY_D;
    end
    if (!bus.if_req || win_if)
      st_nx = '0;
    else if (win_d && (st_cnt != ST_MAX))
      st_nx = st_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
      st_cnt  <= '0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_nx;
      st_cnt  <= st_nx;
    end
  end

`ifndef SYNTHESIS
  a_if_hold: assert property (
    @(posedge clk) disable iff (rst)
    bus.if_req && !bus.if_gnt |=> bus.if_req
  );
  a_d_hold: assert property (
    @(posedge clk) disable iff (rst)
    bus.d_req && !bus.d_gnt |=> bus.d_req
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT 1, 2 and 3
// against a shared pipelined RAM model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   nd;
  logic got_d;
  logic got_if;

  always #5 clk = ~clk;

  mem_port_arbiter_if u1 ();
  mem_port_arbiter_if u2 ();
  mem_port_arbiter_if u3 ();

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst), .bus(u1)
  );
  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut2 (
    .clk(clk), .rst(rst), .bus(u2)
  );
  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst(rst), .bus(u3)
  );

  // word RAM: reset loads C0DE0000 | byte address
  logic [31:0] ram [0:1023];
  logic [31:0] p1;
  logic [31:0] p2 [0:1];
  logic [31:0] p3 [0:2];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++)
        ram[i] <= 32'hC0DE_0000 | 32'(i * 4);
    end else begin
      if (u1.mem_en && u1.mem_wen) ram[u1.mem_addr[11:2]] <= u1.mem_wdata;
      if (u2.mem_en && u2.mem_wen) ram[u2.mem_addr[11:2]] <= u2.mem_wdata;
      if (u3.mem_en && u3.mem_wen) ram[u3.mem_addr[11:2]] <= u3.mem_wdata;
    end
    p1    <= ram[u1.mem_addr[11:2]];
    p2[0] <= ram[u2.mem_addr[11:2]];
    p2[1] <= p2[0];
    p3[0] <= ram[u3.mem_addr[11:2]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign u1.mem_rdata = p1;
  assign u2.mem_rdata = p2[1];
  assign u3.mem_rdata = p3[2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  initial begin
    u1.if_req = 0; u1.if_addr = 0; u1.d_req = 0; u1.d_wen = 0;
    u1.d_mode = 3'b010; u1.d_addr = 0; u1.d_wdata = 0;
    u2.if_req = 0; u2.if_addr = 0; u2.d_req = 0; u2.d_wen = 0;
    u2.d_mode = 3'b010; u2.d_addr = 0; u2.d_wdata = 0;
    u3.if_req = 0; u3.if_addr = 0; u3.d_req = 0; u3.d_wen = 0;
    u3.d_mode = 3'b010; u3.d_addr = 0; u3.d_wdata = 0;
    tick;
    tick;
    rst = 0;
    at_neg;
    chk("rst_mode", 32'(u1.mem_mode), 32'h2);
    chk("rst_en", 32'(u1.mem_en), 0);
    chk("rst_addr", u2.mem_addr, 0);
    chk("rst_ifgnt", 32'(u2.if_gnt), 0);
    chk("rst_drv", 32'(u3.d_rvalid), 0);

    // back-to-back fetches, MEM_LAT=1
    tick; u1.if_req = 1; u1.if_addr = 32'h0;
    at_neg;
    chk("t1_gnt0", 32'(u1.if_gnt), 1);
    chk("t1_rv0", 32'(u1.if_rvalid), 0);
    chk("t1_addr0", u1.mem_addr, 32'h0);
    tick; u1.if_addr = 32'h4;
    at_neg;
    chk("t1_gnt1", 32'(u1.if_gnt), 1);
    chk("t1_rv1", 32'(u1.if_rvalid), 1);
    chk("t1_rd1", u1.if_rdata, 32'hC0DE_0000);
    tick; u1.if_addr = 32'h8;
    at_neg;
    chk("t1_gnt2", 32'(u1.if_gnt), 1);
    chk("t1_addr2", u1.mem_addr, 32'h8);
    chk("t1_rd2", u1.if_rdata, 32'hC0DE_0004);
    tick; u1.if_req = 0;
    at_neg;
    chk("t1_gnt3", 32'(u1.if_gnt), 0);
    chk("t1_rv3", 32'(u1.if_rvalid), 1);
    chk("t1_rd3", u1.if_rdata, 32'hC0DE_0008);
    tick;
    at_neg;
    chk("t1_rv4", 32'(u1.if_rvalid), 0);
    chk("t1_rd4", u1.if_rdata, 0);

    // simultaneous fetch + load, MEM_LAT=2
    tick;
    u2.if_req = 1; u2.if_addr = 32'h40;
    u2.d_req = 1; u2.d_wen = 0; u2.d_addr = 32'h100;
    at_neg;
    chk("t2_dgnt", 32'(u2.d_gnt), 1);
    chk("t2_ifgnt", 32'(u2.if_gnt), 0);
    chk("t2_addr", u2.mem_addr, 32'h100);
    chk("t2_wen", 32'(u2.mem_wen), 0);
    tick; u2.d_req = 0;
    at_neg;
    chk("t2_mid_dgnt", 32'(u2.d_gnt), 0);
    chk("t2_mid_ifgnt", 32'(u2.if_gnt), 0);
    chk("t2_mid_en", 32'(u2.mem_en), 0);
    chk("t2_mid_drv", 32'(u2.d_rvalid), 0);
    tick;
    at_neg;
    chk("t2_drv", 32'(u2.d_rvalid), 1);
    chk("t2_drd", u2.d_rdata, 32'hC0DE_0100);
    chk("t2_ifgnt2", 32'(u2.if_gnt), 1);
    chk("t2_addr2", u2.mem_addr, 32'h40);
    tick; u2.if_req = 0;
    at_neg;
    chk("t2_ifrv3", 32'(u2.if_rvalid), 0);
    chk("t2_drv3", 32'(u2.d_rvalid), 0);
    chk("t2_drd3", u2.d_rdata, 0);
    tick;
    at_neg;
    chk("t2_ifrv4", 32'(u2.if_rvalid), 1);
    chk("t2_ifrd4", u2.if_rdata, 32'hC0DE_0040);
    tick;
    at_neg;
    chk("t2_ifrv5", 32'(u2.if_rvalid), 0);

    // posted store then load back
    tick;
    u2.d_req = 1; u2.d_wen = 1; u2.d_addr = 32'h200;
    u2.d_wdata = 32'hDEAD_BEEF; u2.d_mode = 3'b010;
    at_neg;
    chk("t3_gnt", 32'(u2.d_gnt), 1);
    chk("t3_wen", 32'(u2.mem_wen), 1);
    chk("t3_wdata", u2.mem_wdata, 32'hDEAD_BEEF);
    chk("t3_mode", 32'(u2.mem_mode), 32'h2);
    tick; u2.d_wen = 0; u2.d_wdata = 0;
    at_neg;
    chk("t3_ldgnt", 32'(u2.d_gnt), 1);
    chk("t3_strv", 32'(u2.d_rvalid), 0);
    chk("t3_ldwen", 32'(u2.mem_wen), 0);
    tick; u2.d_req = 0;
    at_neg;
    chk("t3_rv_mid", 32'(u2.d_rvalid), 0);
    tick;
    at_neg;
    chk("t3_rv", 32'(u2.d_rvalid), 1);
    chk("t3_rd", u2.d_rdata, 32'hDEAD_BEEF);

    // store granted in a fetch response slot
    tick; u2.if_req = 1; u2.if_addr = 32'h10;
    at_neg;
    chk("t6_ifgnt", 32'(u2.if_gnt), 1);
    tick;
    u2.if_req = 0;
    u2.d_req = 1; u2.d_wen = 1; u2.d_addr = 32'h204;
    u2.d_wdata = 32'h1234_5678;
    at_neg;
    chk("t6_mid_dgnt", 32'(u2.d_gnt), 0);
    chk("t6_mid_en", 32'(u2.mem_en), 0);
    tick;
    at_neg;
    chk("t6_ifrv", 32'(u2.if_rvalid), 1);
    chk("t6_ifrd", u2.if_rdata, 32'hC0DE_0010);
    chk("t6_dgnt", 32'(u2.d_gnt), 1);
    chk("t6_wen", 32'(u2.mem_wen), 1);
    chk("t6_addr", u2.mem_addr, 32'h204);
    tick;
    u2.d_req = 0; u2.d_wen = 0; u2.d_wdata = 0;
    u2.if_req = 1; u2.if_addr = 32'h204;
    at_neg;
    chk("t6_idle_rv", 32'(u2.if_rvalid), 0);
    chk("t6_idle_gnt", 32'(u2.if_gnt), 1);
    tick; u2.if_req = 0;
    at_neg;
    tick;
    at_neg;
    chk("t6_rdback", u2.if_rdata, 32'h1234_5678);

    // starvation guard: 4 data, 1 fetch, 2 data
    tick;
    at_neg;
    tick;
    u2.if_req = 1; u2.if_addr = 32'h80;
    u2.d_req = 1; u2.d_wen = 0; u2.d_addr = 32'h300;
    nd = 0;
    for (int k = 0; k < 7; k++) begin
      at_neg;
      chk($sformatf("t4_dgnt%0d", k), 32'(u2.d_gnt), 32'(k != 4));
      chk($sformatf("t4_ifgnt%0d", k), 32'(u2.if_gnt), 32'(k == 4));
      got_d  = u2.d_gnt;
      got_if = u2.if_gnt;
      tick;
      if (got_d) begin
        nd++;
        u2.d_addr = u2.d_addr + 32'd4;
        if (nd == 6) u2.d_req = 0;
      end
      if (got_if) u2.if_req = 0;
      at_neg;
      chk($sformatf("t4_mid%0d", k), 32'({u2.d_gnt, u2.if_gnt}), 0);
      tick;
    end
    chk("t4_ndata", 32'(nd), 6);

    // reset one cycle into a MEM_LAT=3 fetch
    tick;
    tick; u3.if_req = 1; u3.if_addr = 32'h20;
    at_neg;
    chk("t5_gnt", 32'(u3.if_gnt), 1);
    tick; u3.if_req = 0; rst = 1;
    at_neg;
    chk("t5_rst_en", 32'(u3.mem_en), 0);
    tick; rst = 0;
    at_neg;
    chk("t5_rv2", 32'(u3.if_rvalid), 0);
    chk("t5_en2", 32'(u3.mem_en), 0);
    chk("t5_mode2", 32'(u3.mem_mode), 32'h2);
    chk("t5_addr2", u3.mem_addr, 0);
    chk("t5_drv2", 32'(u3.d_rvalid), 0);
    tick;
    at_neg;
    chk("t5_rv3", 32'(u3.if_rvalid), 0);
    chk("t5_rd3", u3.if_rdata, 0);
    tick;
    at_neg;
    chk("t5_rv4", 32'(u3.if_rvalid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
